// File: rtl/hkspi_responder.sv
// hkspi_responder: chip-side housekeeping SPI responder.
// Oversamples CSB/SCK/SDI in the system clock domain, decodes the
// command / address / data bytes of a mode-0 SPI transfer and drives a
// byte-wide register-file port with write/read strobes and address
// auto-increment. Read data is returned MSB first on sdo.
// Optional build macro: HKSPI_NBYTE_EN -- when defined, command bits[5:3]
// (n != 0) limit a transaction to n data bytes; otherwise every
// transaction streams until CSB rises.

module hkspi_responder (
  input  logic       clock,
  input  logic       resetb,
  input  logic       csb,
  input  logic       sck,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wstb,
  output logic       reg_rstb,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  // state   | meaning
  // IDLE    | CSB high, or waiting for a fresh CSB fall
  // CMD     | shifting in the command byte
  // ADDR    | shifting in the address byte
  // DATA    | shifting data bytes; read data shifts out on sdo
  // HALT    | no-op until CSB rises (null command or byte limit reached)
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_csb_s1;
  logic       r_csb_s2;
  logic       r_csb_prev;
  logic [1:0] r_sync_ok;
  logic       r_sck_s1;
  logic       r_sck_s2;
  logic       r_sck_s3;
  logic       r_sdi_s1;
  logic       r_sdi_s2;

  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift_in;
  logic [7:0] r_shift_out;
  logic       r_cmd_wr;
  logic       r_cmd_rd;
  logic       r_inc_pend;
  logic       r_rd_req;
  logic       r_load_pend;

  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_csb_fall;
  logic       w_rx_active;
  logic       w_byte_done;
  logic       w_last_byte;
  logic [7:0] w_byte;

`ifdef HKSPI_NBYTE_EN
  logic [2:0] r_cmd_n;
  logic [2:0] r_byte_cnt;
`endif

  // Pin synchronizers; r_sync_ok marks when r_csb_s2 holds a real sample so
  // a CSB already low when reset releases is not mistaken for a fresh fall.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_csb_s1   <= 1'b1;
      r_csb_s2   <= 1'b1;
      r_csb_prev <= 1'b0;
      r_sync_ok  <= 2'b00;
      r_sck_s1   <= 1'b0;
      r_sck_s2   <= 1'b0;
      r_sck_s3   <= 1'b0;
      r_sdi_s1   <= 1'b0;
      r_sdi_s2   <= 1'b0;
    end else begin
      r_csb_s1   <= csb;
      r_csb_s2   <= r_csb_s1;
      r_sync_ok  <= {r_sync_ok[0], 1'b1};
      r_csb_prev <= r_csb_s2 & r_sync_ok[1];
      r_sck_s1   <= sck;
      r_sck_s2   <= r_sck_s1;
      r_sck_s3   <= r_sck_s2;
      r_sdi_s1   <= sdi;
      r_sdi_s2   <= r_sdi_s1;
    end
  end

  assign w_sck_rise  = r_sck_s2 & ~r_sck_s3;
  assign w_sck_fall  = ~r_sck_s2 & r_sck_s3;
  assign w_csb_fall  = r_csb_prev & ~r_csb_s2;
  assign w_rx_active = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_byte      = {r_shift_in, r_sdi_s2};
  // CSB high takes priority, so a byte completing as CSB rises is dropped.
  assign w_byte_done = w_sck_rise & w_rx_active & ~r_csb_s2 & (r_bit_cnt == 3'd7);

`ifdef HKSPI_NBYTE_EN
  assign w_last_byte = (r_cmd_n != 3'd0) && (r_byte_cnt == (r_cmd_n - 3'd1));
`else
  assign w_last_byte = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    if (r_csb_s2) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_csb_fall) w_state_nxt = ST_CMD;
        ST_CMD:  if (w_byte_done) w_state_nxt = (w_byte[7:6] == 2'b00) ? ST_HALT : ST_ADDR;
        ST_ADDR: if (w_byte_done) w_state_nxt = ST_DATA;
        ST_DATA: if (w_byte_done && w_last_byte) w_state_nxt = ST_HALT;
        ST_HALT: w_state_nxt = ST_HALT;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Byte assembly, strobe pipeline (wstb -> increment -> rstb -> load) and
  // the sdo shift register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_bit_cnt   <= 3'd0;
      r_shift_in  <= 7'd0;
      r_shift_out <= 8'd0;
      r_cmd_wr    <= 1'b0;
      r_cmd_rd    <= 1'b0;
      r_inc_pend  <= 1'b0;
      r_rd_req    <= 1'b0;
      r_load_pend <= 1'b0;
      reg_addr    <= 8'd0;
      reg_wdata   <= 8'd0;
      reg_wstb    <= 1'b0;
      reg_rstb    <= 1'b0;
`ifdef HKSPI_NBYTE_EN
      r_cmd_n     <= 3'd0;
      r_byte_cnt  <= 3'd0;
`endif
    end else begin
      reg_wstb    <= 1'b0;
      reg_rstb    <= r_rd_req;
      r_rd_req    <= 1'b0;
      r_inc_pend  <= 1'b0;
      r_load_pend <= reg_rstb;

      if (r_inc_pend) begin
        reg_addr <= reg_addr + 8'd1;
        r_rd_req <= r_cmd_rd;
      end

      // The fall after the 8th rise (bit count back at 0) is left alone so
      // the reload of the next byte is not disturbed.
      if (r_load_pend) begin
        r_shift_out <= reg_rdata;
      end else if (w_sck_fall && (r_state == ST_DATA) && (r_bit_cnt != 3'd0)) begin
        r_shift_out <= {r_shift_out[6:0], 1'b0};
      end

      if (r_state == ST_IDLE) begin
        r_bit_cnt <= 3'd0;
`ifdef HKSPI_NBYTE_EN
        r_byte_cnt <= 3'd0;
`endif
      end else if (w_sck_rise && w_rx_active && !r_csb_s2) begin
        r_shift_in <= w_byte[6:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end

      if (w_byte_done) begin
        unique case (r_state)
          ST_CMD: begin
            r_cmd_wr <= w_byte[7];
            r_cmd_rd <= w_byte[6];
`ifdef HKSPI_NBYTE_EN
            r_cmd_n  <= w_byte[5:3];
`endif
          end
          ST_ADDR: begin
            reg_addr <= w_byte;
            r_rd_req <= r_cmd_rd;
          end
          ST_DATA: begin
            reg_wstb   <= r_cmd_wr;
            if (r_cmd_wr) reg_wdata <= w_byte;
            r_inc_pend <= 1'b1;
`ifdef HKSPI_NBYTE_EN
            r_byte_cnt <= r_byte_cnt + 3'd1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign sdo_oe = (r_state == ST_DATA) && r_cmd_rd;
  assign sdo    = sdo_oe & r_shift_out[7];
  assign busy   = ~r_csb_s2;

endmodule

// File: tb/tb_hkspi_responder.sv
// Testbench for hkspi_responder: SPI host tasks, a ROM-like register bank,
// a transaction-level reference model feeding a strobe/readback scoreboard,
// and directed plus random transactions.

module tb_hkspi_responder;

  localparam int HALF = 8;

  logic       clock = 1'b0;
  logic       resetb = 1'b1;
  logic       csb = 1'b1;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic       sdo;
  logic       sdo_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wstb;
  logic       reg_rstb;
  logic [7:0] reg_rdata = 8'd0;
  logic       busy;

  always #5 clock = ~clock;

  hkspi_responder dut (
    .clock     (clock),
    .resetb    (resetb),
    .csb       (csb),
    .sck       (sck),
    .sdi       (sdi),
    .sdo       (sdo),
    .sdo_oe    (sdo_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wstb  (reg_wstb),
    .reg_rstb  (reg_rstb),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  int         n_checks = 0;
  int         n_fail = 0;
  ev_t        q_exp[$];
  logic [7:0] q_rx_exp[$];
  logic [7:0] q_rx_got[$];
  logic [7:0] bank [256];
  logic [7:0] tx_data [32];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Register bank: read data valid from the cycle after reg_rstb.
  initial begin
    forever begin
      @(negedge clock);
      if (reg_rstb) reg_rdata = bank[reg_addr];
    end
  end

  // Scoreboard monitor: strobes and host-received bytes.
  initial begin : mon
    ev_t        e;
    logic [7:0] got;
    forever begin
      @(negedge clock);
      if (resetb) begin
        if (reg_wstb && reg_rstb) begin
          n_checks++;
          n_fail++;
          $display("FAIL strobe_overlap: wstb and rstb both high at addr %h", reg_addr);
        end
        if (reg_wstb || reg_rstb) begin
          n_checks++;
          if (q_exp.size() == 0) begin
            n_fail++;
            $display("FAIL strobe_unexpected: got wr=%0b addr=%h data=%h, none expected",
                     reg_wstb, reg_addr, reg_wdata);
          end else begin
            e = q_exp.pop_front();
            if ((reg_wstb !== e.wr) || (reg_addr !== e.addr) ||
                (e.wr && (reg_wdata !== e.data))) begin
              n_fail++;
              $display("FAIL strobe: got wr=%0b addr=%h data=%h expected wr=%0b addr=%h data=%h",
                       reg_wstb, reg_addr, reg_wdata, e.wr, e.addr, e.data);
            end
          end
        end
      end
      while (q_rx_got.size() > 0) begin
        got = q_rx_got.pop_front();
        n_checks++;
        if (q_rx_exp.size() == 0) begin
          n_fail++;
          $display("FAIL sdo_byte: got %h, none expected", got);
        end else if (got !== q_rx_exp[0]) begin
          n_fail++;
          $display("FAIL sdo_byte: got %h expected %h", got, q_rx_exp[0]);
          void'(q_rx_exp.pop_front());
        end else begin
          void'(q_rx_exp.pop_front());
        end
      end
    end
  end

  // Reference model: expected strobes and returned bytes for one transaction
  // of n full data bytes.
  task automatic model_txn(input logic [7:0] cmd, input logic [7:0] addr, input int n);
    logic       wr;
    logic       rd;
    logic       active;
    int         lim;
    logic [7:0] a;
    ev_t        e;
    wr     = cmd[7];
    rd     = cmd[6];
    active = (cmd[7:6] != 2'b00);
    lim    = n;
`ifdef HKSPI_NBYTE_EN
    if ((cmd[5:3] != 3'd0) && (int'(cmd[5:3]) < n)) lim = int'(cmd[5:3]);
`endif
    a = addr;
    if (active && rd) begin
      e.wr = 1'b0; e.addr = a; e.data = 8'd0;
      q_exp.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      if (active && (k < lim)) begin
        if (wr) begin
          e.wr = 1'b1; e.addr = a; e.data = tx_data[k];
          q_exp.push_back(e);
        end
        q_rx_exp.push_back(rd ? bank[a] : 8'h00);
        a = a + 8'd1;
        if (rd) begin
          e.wr = 1'b0; e.addr = a; e.data = 8'd0;
          q_exp.push_back(e);
        end
      end else begin
        q_rx_exp.push_back(8'h00);
      end
    end
  endtask

  task automatic sck_half();
    repeat (HALF) @(posedge clock);
    #2;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sdi = tx[7 - i];
      sck_half();
      rx = {rx[6:0], sdo};
      sck = 1'b1;
      sck_half();
      sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    csb = 1'b0;
    sck_half();
    chk("busy_active", {7'd0, busy}, 8'h01);
  endtask

  task automatic cs_end();
    sck_half();
    csb = 1'b1;
    sck_half();
    sck_half();
    chk("busy_idle", {7'd0, busy}, 8'h00);
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input int n,
                         input int partial);
    logic [7:0] rx;
    model_txn(cmd, addr, n);
    cs_start();
    spi_bits(cmd, 8, rx);
    spi_bits(addr, 8, rx);
    for (int k = 0; k < n; k++) begin
      spi_bits(tx_data[k], 8, rx);
      q_rx_got.push_back(rx);
    end
    if (partial > 0) spi_bits(8'hA5, partial, rx);
    cs_end();
  endtask

  initial begin : stim
    logic [7:0] rx;
    logic [7:0] cmd;
    logic [7:0] pick [4];
    pick[0] = 8'h80; pick[1] = 8'h40; pick[2] = 8'hC0; pick[3] = 8'h00;
    for (int i = 0; i < 256; i++) bank[i] = 8'($urandom);
    bank[8'h03] = 8'h20;
    bank[8'h10] = 8'h33;

    #1 resetb = 1'b0;
    #10;
    chk("rst_sdo", {7'd0, sdo}, 8'h00);
    chk("rst_sdo_oe", {7'd0, sdo_oe}, 8'h00);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_wstb", {7'd0, reg_wstb}, 8'h00);
    chk("rst_rstb", {7'd0, reg_rstb}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    repeat (3) @(posedge clock);
    #2 resetb = 1'b1;
    repeat (5) @(posedge clock);
    #2;

    tx_data[0] = 8'h01;
    run_txn(8'h80, 8'h0b, 1, 0);

    tx_data[0] = 8'h00;
    run_txn(8'h40, 8'h03, 1, 0);

    for (int k = 0; k < 19; k++) tx_data[k] = 8'($urandom);
    run_txn(8'h40, 8'h00, 19, 0);

    tx_data[0] = 8'hA1; tx_data[1] = 8'hB2; tx_data[2] = 8'hC3;
    run_txn(8'h80, 8'hFE, 3, 0);

    tx_data[0] = 8'h5A;
    run_txn(8'hC0, 8'h10, 1, 4);

    // Reset in the middle of a data byte of a read-write transaction.
    tx_data[0] = 8'h77;
    model_txn(8'hC0, 8'h40, 1);
    cs_start();
    spi_bits(8'hC0, 8, rx);
    spi_bits(8'h40, 8, rx);
    spi_bits(tx_data[0], 8, rx);
    q_rx_got.push_back(rx);
    spi_bits(8'hF0, 4, rx);
    chk("pre_rst_sdo_oe", {7'd0, sdo_oe}, 8'h01);
    resetb = 1'b0;
    #3;
    chk("mid_rst_sdo", {7'd0, sdo}, 8'h00);
    chk("mid_rst_sdo_oe", {7'd0, sdo_oe}, 8'h00);
    chk("mid_rst_addr", reg_addr, 8'h00);
    chk("mid_rst_wdata", reg_wdata, 8'h00);
    chk("mid_rst_wstb", {7'd0, reg_wstb}, 8'h00);
    chk("mid_rst_rstb", {7'd0, reg_rstb}, 8'h00);
    chk("mid_rst_busy", {7'd0, busy}, 8'h00);
    sck_half();
    resetb = 1'b1;
    spi_bits(8'h3C, 8, rx);
    spi_bits(8'h81, 8, rx);
    chk("post_rst_sdo_oe", {7'd0, sdo_oe}, 8'h00);
    cs_end();
    chk("post_rst_addr", reg_addr, 8'h00);

    tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33;
    run_txn(8'h90, 8'h20, 3, 0);

    for (int t = 0; t < 20; t++) begin
      cmd = pick[$urandom_range(0, 3)] | 8'($urandom_range(0, 7) << 3);
      for (int k = 0; k < 6; k++) tx_data[k] = 8'($urandom);
      run_txn(cmd, 8'($urandom), $urandom_range(1, 5), 0);
    end

    repeat (40) @(posedge clock);
    #2;
    chk("strobes_outstanding", 8'(q_exp.size()), 8'h00);
    chk("bytes_outstanding", 8'(q_rx_exp.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hkspi_responder.md
# hkspi_responder

Housekeeping SPI responder: the chip-side end of the housekeeping SPI link driven by an external host on mprj_io[4:2] (SCK, CSB, SDI), returning data on mprj_io[1] (SDO). It oversamples the SPI pins in the system clock domain, decodes command/address/data bytes, and drives a byte-wide register-file port with write and read strobes and address auto-increment. It sits between the pad mux and the housekeeping register bank.

## Interface
- No parameters.
- clock  in  1  system clock; must be ≥ 8× SCK frequency
- resetb  in  1  asynchronous active-low reset
- csb  in  1  SPI chip select, active low, asynchronous to clock
- sck  in  1  SPI clock, mode 0, asynchronous to clock
- sdi  in  1  SPI serial data in, MSB first
- sdo  out  1  SPI serial data out, MSB first
- sdo_oe  out  1  high while sdo is being driven
- reg_addr  out  8  register address
- reg_wdata  out  8  write data, valid with reg_wstb
- reg_wstb  out  1  one-cycle write strobe
- reg_rstb  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid the cycle after reg_rstb
- busy  out  1  high while CSB (synchronized) is low

## Operation
- csb, sck, sdi pass through 2-flop synchronizers; a third flop on sck gives rise/fall detect. All logic acts on synchronized values.
- States: IDLE, CMD, ADDR, DATA, HALT. Synchronized CSB falling: IDLE→CMD, bit counter = 0. Synchronized CSB high: any state→IDLE, partial byte discarded, no strobe.
- Bits shift in on detected SCK rise; byte complete on 8th rise.
- CMD byte: bit7 = write, bit6 = read, bits[5:3] = byte count n (see Configuration). Bits[7:6] = 00 → HALT (no-op until CSB high). Otherwise →ADDR.
- ADDR byte complete: reg_addr loaded; if read, reg_rstb pulses next cycle; →DATA.
- DATA byte complete: if write, reg_wstb pulses with reg_wdata = received byte at current reg_addr; next cycle reg_addr increments (0xFF wraps to 0x00); if read, reg_rstb pulses the cycle after the increment. Read-write (0xC0): same byte both returns old data and writes new.
- Read: cycle after reg_rstb, reg_rdata loads the out shift register; sdo = its MSB. Shift left on each detected SCK fall of the data byte, so bit 7 is valid before the first data-byte SCK rise.
- sdo_oe high in DATA when read bit set; otherwise low and sdo = 0.

## Timing
- Reset values: sdo 0, sdo_oe 0, reg_addr 0x00, reg_wdata 0x00, reg_wstb 0, reg_rstb 0, busy 0, state IDLE.
- Pin-to-detect latency: 3 clocks. reg_wstb at detect+1; reg_addr increment at detect+2; reg_rstb at detect+3; shift-register load at detect+4. All complete before the following SCK fall given the 8× ratio.
- reg_wstb and reg_rstb never assert in the same cycle; each is exactly one cycle wide.
- CSB rise coincident with 8th SCK rise: CSB wins; no strobe.
- resetb asserted mid-transfer: immediate return to reset values; the rest of the transfer is ignored until next CSB fall.

## Configuration
- HKSPI_NBYTE_EN defined: CMD bits[5:3] = n ≠ 0 limits the transaction to n data bytes; after the nth byte completes →HALT, further SCK ignored, sdo_oe low. n = 0 streams until CSB high.
- Not defined: bits[5:3] ignored; all transactions stream.

## Test plan
- Write 0x80, 0x0b, 0x01 → exactly one reg_wstb with reg_addr 0x0b, reg_wdata 0x01; CSB high → busy 0.
- Read 0x40, 0x03, model returns 0x20 at addr 0x03 → host shifts in 0x20 on SDO; one reg_rstb at 0x03, one at 0x04.
- Read stream 0x40, 0x00, 19 bytes, model data = addr table → host receives table[0..18] in order, addresses 0x00..0x13 strobed.
- Write stream from 0xFE, 3 bytes → writes at 0xFE, 0xFF, 0x00 (wrap).
- Command 0xC0, 0x10, send 0x5A with model 0x33 → SDO returns 0x33, reg_wstb at 0x10 with 0x5A; CSB raised after 4 bits of next byte → no further strobe. resetb pulsed mid-byte → all outputs return to reset values.
- With HKSPI_NBYTE_EN: 0x90 (n=2), 0x20, 3 data bytes → two strobes (0x20, 0x21), third ignored; without macro → three strobes.
